// File: rtl/npu_out_collector.sv
// npu_out_collector: packs the NPU core's byte output stream little-endian into 32-bit
// words, queues them in a small FIFO and writes them out over a req/ack port.
// The core cannot be stalled, so a word arriving at a full FIFO is dropped and flagged.
// Optional build macro: NPU_OUT_MINMAX_EN enables signed max/min tracking of accepted bytes.
module npu_out_collector #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RESET_X,
  input  logic              SOFT_RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [CNT_W-1:0]  LENGTH,
  input  logic              IN_EN,
  input  logic [7:0]        C_IN,
  output logic              WR_REQ,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [31:0]       WR_DATA,
  output logic [3:0]        WR_BE,
  input  logic              WR_ACK,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERFLOW,
  output logic [CNT_W-1:0]  BYTE_CNT,
  output logic [7:0]        ST_MAX,
  output logic [7:0]        ST_MIN
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FcntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StFin} state_e;

  state_e              state_q, state_d;
  logic                rst;
  logic                start_ok, accept, last_byte, word_done;
  logic [CNT_W-1:0]    len_q, byte_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         pack_data_q, lane_data, word_data;
  logic [3:0]          pack_be_q, word_be;
  logic [1:0]          lane_q;
  logic                push_pend_q;
  logic [31:0]         push_data_q;
  logic [3:0]          push_be_q;
  logic                overflow_q;
  logic                fifo_full, fifo_empty, push_ok, pop, drop;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FcntW-1:0]    fcnt_q;
  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [31:0]         fifo_data [FIFO_DEPTH];
  logic [3:0]          fifo_be   [FIFO_DEPTH];
  logic                unused_base;

  // Word alignment discards the low address bits.
  assign unused_base = ^BASE_ADDR[1:0];

  assign rst        = !RESET_X || SOFT_RESET;
  assign start_ok   = START && (state_q == StIdle);
  assign accept     = IN_EN && (state_q == StRun) && (byte_cnt_q < len_q);
  assign last_byte  = accept && ((byte_cnt_q + CNT_W'(1)) == len_q);
  assign word_done  = accept && ((lane_q == 2'd3) || last_byte);
  assign lane_data  = {24'b0, C_IN} << {lane_q, 3'b000};
  assign word_data  = pack_data_q | lane_data;
  assign word_be    = pack_be_q | (4'b0001 << lane_q);

  assign fifo_full  = (fcnt_q == FcntW'(FIFO_DEPTH));
  assign fifo_empty = (fcnt_q == '0);
  assign pop        = !fifo_empty && WR_ACK;
  // A simultaneous pop frees the slot, so a push at full still lands.
  assign push_ok    = push_pend_q && (!fifo_full || pop);
  assign drop       = push_pend_q && fifo_full && !pop;

  // State register.
  always_ff @(posedge CLK) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; FLUSH also waits out a word still on its way into the FIFO.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (START) state_d = (LENGTH == '0) ? StFin : StRun;
      StRun:   if (last_byte) state_d = StFlush;
      StFlush: if (fifo_empty && !push_pend_q) state_d = StFin;
      StFin:   state_d = StIdle;
    endcase
  end

  // Job registers, byte packer and the one-cycle push stage.
  always_ff @(posedge CLK) begin
    if (rst) begin
      len_q       <= '0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      pack_data_q <= '0;
      pack_be_q   <= '0;
      lane_q      <= '0;
      push_pend_q <= 1'b0;
      push_data_q <= '0;
      push_be_q   <= '0;
      overflow_q  <= 1'b0;
    end else if (start_ok) begin
      len_q       <= LENGTH;
      byte_cnt_q  <= '0;
      addr_q      <= {BASE_ADDR[ADDR_W-1:2], 2'b00};
      pack_data_q <= '0;
      pack_be_q   <= '0;
      lane_q      <= '0;
      push_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      push_pend_q <= word_done;
      if (accept) begin
        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
        if (word_done) begin
          push_data_q <= word_data;
          push_be_q   <= word_be;
          pack_data_q <= '0;
          pack_be_q   <= '0;
          lane_q      <= '0;
        end else begin
          pack_data_q <= word_data;
          pack_be_q   <= word_be;
          lane_q      <= lane_q + 2'd1;
        end
      end
      // Dropped words still consume their address slot.
      if (push_pend_q) addr_q <= addr_q + ADDR_W'(4);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      fcnt_q <= fcnt_q + FcntW'(push_ok) - FcntW'(pop);
    end
  end

  // FIFO storage; contents are don't-care until written, outputs are masked when empty.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      fifo_addr[wr_ptr_q] <= addr_q;
      fifo_data[wr_ptr_q] <= push_data_q;
      fifo_be[wr_ptr_q]   <= push_be_q;
    end
  end

  // Write port and status outputs, all derived from registered state.
  always_comb begin
    WR_REQ   = !fifo_empty;
    WR_ADDR  = WR_REQ ? fifo_addr[rd_ptr_q] : '0;
    WR_DATA  = WR_REQ ? fifo_data[rd_ptr_q] : '0;
    WR_BE    = WR_REQ ? fifo_be[rd_ptr_q]   : '0;
    BUSY     = (state_q != StIdle);
    DONE     = (state_q == StFin);
    OVERFLOW = overflow_q;
    BYTE_CNT = byte_cnt_q;
  end

`ifdef NPU_OUT_MINMAX_EN
  logic [7:0] st_max_q, st_min_q;

  // Signed running max/min of accepted bytes; START seeds the extreme opposites.
  always_ff @(posedge CLK) begin
    if (rst) begin
      st_max_q <= '0;
      st_min_q <= '0;
    end else if (start_ok) begin
      st_max_q <= 8'h80;
      st_min_q <= 8'h7F;
    end else if (accept) begin
      if ($signed(C_IN) > $signed(st_max_q)) st_max_q <= C_IN;
      if ($signed(C_IN) < $signed(st_min_q)) st_min_q <= C_IN;
    end
  end

  assign ST_MAX = st_max_q;
  assign ST_MIN = st_min_q;
`else
  assign ST_MAX = 8'h00;
  assign ST_MIN = 8'h00;
`endif

endmodule

// File: tb/tb_npu_out_collector.sv
// Self-checking bench for npu_out_collector: table-driven jobs plus hand-written corner
// sequences; expected writes are queued as bytes are driven and checked as they are acked.
module tb_npu_out_collector;

  logic        CLK = 1'b0;
  logic        RESET_X = 1'b0;
  logic        SOFT_RESET = 1'b0;
  logic        START = 1'b0;
  logic [31:0] BASE_ADDR = '0;
  logic [15:0] LENGTH = '0;
  logic        IN_EN = 1'b0;
  logic [7:0]  C_IN = '0;
  logic        WR_REQ;
  logic [31:0] WR_ADDR;
  logic [31:0] WR_DATA;
  logic [3:0]  WR_BE;
  logic        WR_ACK = 1'b0;
  logic        BUSY, DONE, OVERFLOW;
  logic [15:0] BYTE_CNT;
  logic [7:0]  ST_MAX, ST_MIN;

  npu_out_collector #(
    .FIFO_DEPTH(8),
    .ADDR_W(32),
    .CNT_W(16)
  ) dut (
    .CLK(CLK), .RESET_X(RESET_X), .SOFT_RESET(SOFT_RESET), .START(START),
    .BASE_ADDR(BASE_ADDR), .LENGTH(LENGTH), .IN_EN(IN_EN), .C_IN(C_IN),
    .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_BE(WR_BE),
    .WR_ACK(WR_ACK), .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW),
    .BYTE_CNT(BYTE_CNT), .ST_MAX(ST_MAX), .ST_MIN(ST_MIN)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [31:0] base;
    int          len;
    int          n_in;
    int          gap;
    int          mode;      // 0: 11,22,33.. 1: random 2: user_bytes
    int          ack;       // 0: low 1: high 2: random
    logic [15:0] exp_cnt;
    int          exp_words;
  } vec_t;

  wr_t        exp_q[$];
  logic [7:0] user_bytes[$];
  int         tests = 0;
  int         fails = 0;
  int         n_writes = 0;
  int         done_pulses = 0;
  int         ack_mode = 1;
  int         push_limit = 1000000;
  logic [7:0] exp_max, exp_min;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Acknowledge driver.
  always @(posedge CLK) begin
    #1;
    case (ack_mode)
      0:       WR_ACK = 1'b0;
      1:       WR_ACK = 1'b1;
      default: WR_ACK = 1'($urandom_range(0, 1));
    endcase
  end

  // Write monitor: hold-stability check, scoreboard pop and DONE counting.
  logic prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
  wr_t  prev_wr;
  always @(negedge CLK) begin
    if (DONE) done_pulses++;
    if (!prev_rst && prev_req && !prev_ack) begin
      check("hold_req", WR_REQ, 1'b1);
      check("hold_addr", WR_ADDR, prev_wr.addr);
      check("hold_data", WR_DATA, prev_wr.data);
      check("hold_be", WR_BE, prev_wr.be);
    end
    if (WR_REQ && WR_ACK && RESET_X && !SOFT_RESET) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 WR_ADDR, WR_DATA);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", WR_ADDR, e.addr);
        check("wr_data", WR_DATA, e.data);
        check("wr_be", WR_BE, e.be);
      end
    end
    prev_req = WR_REQ;
    prev_ack = WR_ACK;
    prev_rst = !RESET_X || SOFT_RESET;
    prev_wr  = '{addr: WR_ADDR, data: WR_DATA, be: WR_BE};
  end

  // Starts a job, drives n_in bytes and queues the writes a correct collector must make.
  task automatic drive_job(input logic [31:0] base, input int len, input int n_in,
                           input int gap, input int mode);
    logic [31:0] wd = '0;
    logic [3:0]  wb = '0;
    logic [7:0]  b;
    int          w = 0;
    exp_max = 8'h80;
    exp_min = 8'h7F;
    START = 1'b1; BASE_ADDR = base; LENGTH = 16'(len);
    @(posedge CLK); #1;
    START = 1'b0;
    for (int i = 0; i < n_in; i++) begin
      if (mode == 0)      b = 8'((i + 1) * 17);
      else if (mode == 1) b = 8'($urandom);
      else                b = user_bytes[i];
      IN_EN = 1'b1;
      C_IN  = b;
      if (i < len) begin
        wd[8*(i%4) +: 8] = b;
        wb[i%4] = 1'b1;
        if ($signed(b) > $signed(exp_max)) exp_max = b;
        if ($signed(b) < $signed(exp_min)) exp_min = b;
        if ((i % 4 == 3) || (i == len - 1)) begin
          if (w < push_limit)
            exp_q.push_back('{addr: {base[31:2], 2'b00} + 32'(4 * w), data: wd, be: wb});
          w++;
          wd = '0;
          wb = '0;
        end
      end
      @(posedge CLK); #1;
      IN_EN = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge CLK); #1;
      end
    end
    IN_EN = 1'b0;
  endtask

  // Waits (bounded) for DONE, then checks the job's end state.
  task automatic finish_job(input int d0, input int w0, input int exp_words,
                            input logic [15:0] exp_cnt, input logic exp_ovf);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge CLK);
      if (done_pulses != d0) break;
    end
    if (k == 2000) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no DONE in 2000 cycles, expected DONE");
    end
    repeat (2) @(negedge CLK);
    check("done_pulses", done_pulses - d0, 1);
    check("busy_after", BUSY, 1'b0);
    check("n_writes", n_writes - w0, exp_words);
    check("queue_drained", exp_q.size(), 0);
    check("byte_cnt", BYTE_CNT, exp_cnt);
    check("overflow", OVERFLOW, exp_ovf);
`ifdef NPU_OUT_MINMAX_EN
    check("st_max", ST_MAX, exp_max);
    check("st_min", ST_MIN, exp_min);
`else
    check("st_max", ST_MAX, 8'h00);
    check("st_min", ST_MIN, 8'h00);
`endif
  endtask

  vec_t vecs[6];
  int   d0, w0, k;

  initial begin
    vecs[0] = '{32'h0000_1000, 4, 4, 0, 0, 1, 16'd4, 1};
    vecs[1] = '{32'h0000_1000, 6, 8, 0, 0, 1, 16'd6, 2};
    vecs[2] = '{32'h0000_2003, 5, 5, 1, 1, 2, 16'd5, 2};
    vecs[3] = '{32'h0000_FFFE, 13, 13, 0, 1, 1, 16'd13, 4};
    vecs[4] = '{32'h8000_0010, 1, 3, 0, 1, 1, 16'd1, 1};
    vecs[5] = '{32'h0000_4000, 37, 40, 1, 1, 2, 16'd37, 10};

    // Reset state.
    repeat (3) @(posedge CLK);
    #1 RESET_X = 1'b1;
    @(negedge CLK);
    check("rst_wr_req", WR_REQ, 1'b0);
    check("rst_wr_addr", WR_ADDR, 32'h0);
    check("rst_wr_data", WR_DATA, 32'h0);
    check("rst_wr_be", WR_BE, 4'h0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_overflow", OVERFLOW, 1'b0);
    check("rst_byte_cnt", BYTE_CNT, 16'h0);
    check("rst_st_max", ST_MAX, 8'h00);
    check("rst_st_min", ST_MIN, 8'h00);
    @(posedge CLK); #1;

    // Table-driven jobs.
    for (int v = 0; v < 6; v++) begin
      ack_mode = vecs[v].ack;
      d0 = done_pulses;
      w0 = n_writes;
      drive_job(vecs[v].base, vecs[v].len, vecs[v].n_in, vecs[v].gap, vecs[v].mode);
      finish_job(d0, w0, vecs[v].exp_words, vecs[v].exp_cnt, 1'b0);
      ack_mode = 1;
      @(posedge CLK); #1;
    end

    // Latency: 4th byte in cycle t -> push in t+1 -> WR_REQ in t+2.
    d0 = done_pulses; w0 = n_writes;
    drive_job(32'h0000_1000, 4, 4, 0, 0);
    @(negedge CLK);
    check("lat_req_t1", WR_REQ, 1'b0);
    @(negedge CLK);
    check("lat_req_t2", WR_REQ, 1'b1);
    finish_job(d0, w0, 1, 16'd4, 1'b0);

    // LENGTH=0: straight to FIN, DONE in the cycle after START, no writes.
    d0 = done_pulses; w0 = n_writes;
    exp_max = 8'h80; exp_min = 8'h7F;
    START = 1'b1; BASE_ADDR = 32'h1000; LENGTH = 16'd0;
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    check("len0_done", DONE, 1'b1);
    check("len0_busy", BUSY, 1'b1);
    @(negedge CLK);
    check("len0_done_off", DONE, 1'b0);
    check("len0_busy_off", BUSY, 1'b0);
    check("len0_req", WR_REQ, 1'b0);
    finish_job(d0, w0, 0, 16'd0, 1'b0);

    // START while busy is ignored.
    d0 = done_pulses; w0 = n_writes;
    START = 1'b1; BASE_ADDR = 32'h2000; LENGTH = 16'd4;
    @(posedge CLK); #1;
    START = 1'b0;
    IN_EN = 1'b1; C_IN = 8'hAA; @(posedge CLK); #1;
    C_IN = 8'hBB; @(posedge CLK); #1;
    C_IN = 8'hCC; START = 1'b1; BASE_ADDR = 32'h3000; LENGTH = 16'd1;
    @(posedge CLK); #1;
    START = 1'b0; C_IN = 8'hDD; @(posedge CLK); #1;
    IN_EN = 1'b0;
    exp_q.push_back('{addr: 32'h2000, data: 32'hDDCC_BBAA, be: 4'hF});
    exp_max = 8'hDD; exp_min = 8'hAA;
    finish_job(d0, w0, 1, 16'd4, 1'b0);

    // Overflow: no acks, 10 words into an 8-deep FIFO.
    ack_mode = 0;
    push_limit = 8;
    d0 = done_pulses; w0 = n_writes;
    drive_job(32'h0000_1000, 40, 40, 0, 1);
    repeat (3) @(negedge CLK);
    check("ovf_flag", OVERFLOW, 1'b1);
    check("ovf_req", WR_REQ, 1'b1);
    check("ovf_busy", BUSY, 1'b1);
    check("ovf_cnt", BYTE_CNT, 16'd40);
    ack_mode = 1;
    finish_job(d0, w0, 8, 16'd40, 1'b1);
    push_limit = 1000000;

    // SOFT_RESET clears the sticky flag.
    @(posedge CLK); #1 SOFT_RESET = 1'b1;
    @(posedge CLK); #1 SOFT_RESET = 1'b0;
    @(negedge CLK);
    check("srst_overflow", OVERFLOW, 1'b0);
    check("srst_byte_cnt", BYTE_CNT, 16'h0);

    // Reset while a write is pending.
    ack_mode = 0;
    drive_job(32'h0000_1000, 8, 4, 0, 0);
    for (k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (WR_REQ) break;
    end
    check("mid_req_seen", WR_REQ, 1'b1);
    RESET_X = 1'b0;
    @(posedge CLK); #1;
    RESET_X = 1'b1;
    exp_q.delete();
    ack_mode = 1;
    @(negedge CLK);
    check("mid_wr_req", WR_REQ, 1'b0);
    check("mid_busy", BUSY, 1'b0);
    check("mid_wr_addr", WR_ADDR, 32'h0);
    check("mid_wr_data", WR_DATA, 32'h0);
    check("mid_byte_cnt", BYTE_CNT, 16'h0);
    @(posedge CLK); #1;
    d0 = done_pulses; w0 = n_writes;
    drive_job(32'h0000_1000, 6, 6, 0, 0);
    finish_job(d0, w0, 2, 16'd6, 1'b0);

    // Signed min/max extremes.
    user_bytes = '{8'h05, 8'hF0, 8'h7F, 8'h80};
    d0 = done_pulses; w0 = n_writes;
    drive_job(32'h0000_1000, 4, 4, 0, 2);
    finish_job(d0, w0, 1, 16'd4, 1'b0);
`ifdef NPU_OUT_MINMAX_EN
    check("mm_max", ST_MAX, 8'h7F);
    check("mm_min", ST_MIN, 8'h80);
`else
    check("mm_max", ST_MAX, 8'h00);
    check("mm_min", ST_MIN, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
